// File: rtl/id_ex_stage_pipeline_if.sv
// ID/EX boundary bundle: decode-side operands/control in, EX-side registered view out.
// Optional perf counters are present only when ID_EX_PERF_CNT_EN is defined.
interface id_ex_stage_pipeline_if #(
    parameter int unsigned DATA_W = 32
`ifdef ID_EX_PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
);
    logic              id_valid_i;
    logic [DATA_W-1:0] pc_i;
    logic [DATA_W-1:0] instr_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [15:0]       ctrl_i;
    logic              ex_stall_i;
    logic              ex_flush_i;
    logic              id_stall_o;
    logic              ex_valid_o;
    logic [DATA_W-1:0] ex_pc_o;
    logic [DATA_W-1:0] ex_instr_o;
    logic [DATA_W-1:0] ex_rs1_data_o;
    logic [DATA_W-1:0] ex_rs2_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [15:0]       ex_ctrl_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;
`endif

    modport master (
        output id_valid_i, pc_i, instr_i, rs1_data_i, rs2_data_i, imm_i, ctrl_i,
               ex_stall_i, ex_flush_i,
        input  id_stall_o, ex_valid_o, ex_pc_o, ex_instr_o, ex_rs1_data_o,
               ex_rs2_data_o, ex_imm_o, ex_ctrl_o
`ifdef ID_EX_PERF_CNT_EN
        , input bubble_cnt_o, flush_cnt_o
`endif
    );

    modport slave (
        input  id_valid_i, pc_i, instr_i, rs1_data_i, rs2_data_i, imm_i, ctrl_i,
               ex_stall_i, ex_flush_i,
        output id_stall_o, ex_valid_o, ex_pc_o, ex_instr_o, ex_rs1_data_o,
               ex_rs2_data_o, ex_imm_o, ex_ctrl_o
`ifdef ID_EX_PERF_CNT_EN
        , output bubble_cnt_o, flush_cnt_o
`endif
    );
endinterface

// File: rtl/id_ex_stage_pipeline.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and stall hold.
// Define ID_EX_PERF_CNT_EN to add saturating bubble/flush counters.
module id_ex_stage_pipeline #(
    parameter int unsigned DATA_W = 32
`ifdef ID_EX_PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    id_ex_stage_pipeline_if.slave bus
);
    localparam int unsigned CTRL_W     = 16;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned BIT_IS_LOAD = 11;
    localparam int unsigned BIT_IS_RS2  = 9;
    localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013);

    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_pc_q;
    logic [DATA_W-1:0] ex_instr_q;
    logic [DATA_W-1:0] ex_rs1_data_q;
    logic [DATA_W-1:0] ex_rs2_data_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [CTRL_W-1:0] ex_ctrl_q;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic [4:0]           id_opcode;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 hazard;
    logic                 load_bubble;

    assign id_rs1    = bus.instr_i[19:15];
    assign id_rs2    = bus.instr_i[24:20];
    assign id_opcode = bus.instr_i[6:2];
    assign ex_rd     = ex_instr_q[11:7];

    // LUI, AUIPC and JAL carry no rs1 field, so their bits must not raise a hazard
    assign uses_rs1 = !((id_opcode == 5'b01101) || (id_opcode == 5'b00101) ||
                        (id_opcode == 5'b11011));
    assign uses_rs2 = bus.ctrl_i[BIT_IS_RS2];

    assign hazard = bus.id_valid_i && ex_valid_q && ex_ctrl_q[BIT_IS_LOAD] &&
                    (ex_rd != '0) &&
                    ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));

    assign load_bubble   = bus.ex_flush_i || hazard;
    assign bus.id_stall_o = bus.ex_stall_i || (hazard && !bus.ex_flush_i);

    // Stall holds everything; otherwise bubble or capture
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_instr_q    <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
        end else if (!bus.ex_stall_i) begin
            if (load_bubble) begin
                ex_valid_q <= 1'b0;
                ex_ctrl_q  <= '0;
                ex_instr_q <= NOP_INSTR;
            end else begin
                ex_valid_q    <= bus.id_valid_i;
                ex_pc_q       <= bus.pc_i;
                ex_instr_q    <= bus.instr_i;
                ex_rs1_data_q <= bus.rs1_data_i;
                ex_rs2_data_q <= bus.rs2_data_i;
                ex_imm_q      <= bus.imm_i;
                ex_ctrl_q     <= bus.id_valid_i ? bus.ctrl_i : '0;
            end
        end
    end

    assign bus.ex_valid_o    = ex_valid_q;
    assign bus.ex_pc_o       = ex_pc_q;
    assign bus.ex_instr_o    = ex_instr_q;
    assign bus.ex_rs1_data_o = ex_rs1_data_q;
    assign bus.ex_rs2_data_o = ex_rs2_data_q;
    assign bus.ex_imm_o      = ex_imm_q;
    assign bus.ex_ctrl_o     = ex_ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Flush takes precedence, so a cycle counts toward exactly one counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (!bus.ex_stall_i) begin
            if (bus.ex_flush_i) begin
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else if (hazard) begin
                if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage_pipeline.sv
// Self-checking bench for id_ex_stage_pipeline: directed scenarios plus random traffic
// against a slot-level reference model of the EX stage.
module tb_id_ex_stage_pipeline;
    localparam int unsigned DATA_W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_pipeline_if #(.DATA_W(DATA_W)) bus ();

    id_ex_stage_pipeline #(.DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of the EX slot
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_imm;
    logic [15:0] m_ctrl;
    logic        m_data_known;
    logic [31:0] m_bcnt, m_fcnt;
    logic        obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
        logic [4:0] a, b, c;
        a = 5'(rd); b = 5'(rs1); c = 5'(rs2);
        return {7'b0, c, b, 3'b0, a, opc};
    endfunction

    // ctrl: [15]rd_wren [11]is_load [9]is_rs2, other bits random
    function automatic logic [15:0] mk_ctrl(input logic ld, input logic rs2u);
        logic [15:0] c;
        c = 16'($urandom);
        c[11] = ld;
        c[9]  = rs2u;
        return c;
    endfunction

    // Spec-level hazard rule evaluated on the model's EX slot
    function automatic logic ref_hazard(input logic idv, input logic [31:0] ins, input logic [15:0] ctl);
        logic [6:0] opc;
        logic       r1, r2;
        int         ex_rd;
        opc   = ins[6:0];
        ex_rd = int'(m_instr[11:7]);
        r1 = !(opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111);
        r2 = ctl[9];
        if (!idv || !m_valid || !m_ctrl[11] || ex_rd == 0) return 1'b0;
        return (r1 && int'(ins[19:15]) == ex_rd) || (r2 && int'(ins[24:20]) == ex_rd);
    endfunction

    task automatic step(input logic rst, input logic idv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [15:0] ctl,
                        input logic stall, input logic flush);
        logic haz;
        logic [31:0] d1, d2, im;
        d1 = $urandom; d2 = $urandom; im = $urandom;
        @(negedge clk);
        rst_n = rst;
        bus.id_valid_i = idv; bus.pc_i = pc; bus.instr_i = ins;
        bus.rs1_data_i = d1; bus.rs2_data_i = d2; bus.imm_i = im;
        bus.ctrl_i = ctl; bus.ex_stall_i = stall; bus.ex_flush_i = flush;
        #1;
        haz = ref_hazard(idv, ins, ctl);
        obs_stall = bus.id_stall_o;
        if (rst) chk("id_stall", 32'(bus.id_stall_o), 32'(stall | (haz & ~flush)));
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_pc = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
            m_ctrl = 0; m_data_known = 1; m_bcnt = 0; m_fcnt = 0;
        end else if (!stall) begin
            if (flush || haz) begin
                m_valid = 0; m_ctrl = 0; m_instr = 32'h13; m_data_known = 0;
                if (flush) begin if (m_fcnt != '1) m_fcnt++; end
                else begin if (m_bcnt != '1) m_bcnt++; end
            end else begin
                m_valid = idv; m_pc = pc; m_instr = ins; m_rs1 = d1; m_rs2 = d2;
                m_imm = im; m_ctrl = idv ? ctl : 16'h0; m_data_known = 1;
            end
        end
        #1;
        chk("ex_valid", 32'(bus.ex_valid_o), 32'(m_valid));
        chk("ex_ctrl", 32'(bus.ex_ctrl_o), 32'(m_ctrl));
        chk("ex_instr", bus.ex_instr_o, m_instr);
        if (m_data_known) begin
            chk("ex_pc", bus.ex_pc_o, m_pc);
            chk("ex_rs1", bus.ex_rs1_data_o, m_rs1);
            chk("ex_rs2", bus.ex_rs2_data_o, m_rs2);
            chk("ex_imm", bus.ex_imm_o, m_imm);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", 32'(bus.bubble_cnt_o), m_bcnt);
        chk("flush_cnt", 32'(bus.flush_cnt_o), m_fcnt);
`endif
    endtask

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    initial begin
        logic [6:0]  opcs [6];
        logic [31:0] lw5, add_dep;
        logic [31:0] bcnt_before;
        checks = 0; errors = 0;
        opcs[0] = OP_R; opcs[1] = OP_LD; opcs[2] = OP_IMM;
        opcs[3] = OP_LUI; opcs[4] = OP_AUI; opcs[5] = OP_JAL;
        rst_n = 1'b0;
        bus.id_valid_i = 0; bus.pc_i = 0; bus.instr_i = 0; bus.rs1_data_i = 0;
        bus.rs2_data_i = 0; bus.imm_i = 0; bus.ctrl_i = 0;
        bus.ex_stall_i = 0; bus.ex_flush_i = 0;

        // Reset state
        step(0, 1, 32'h100, enc(OP_R, 1, 2, 3), 16'hFFFF, 0, 0);
        step(0, 1, 32'h104, enc(OP_R, 1, 2, 3), 16'hFFFF, 0, 0);
        chk("reset_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("reset_instr", bus.ex_instr_o, 32'd0);

        // Load-use: lw x5 then add x6,x5,x7
        lw5     = enc(OP_LD, 5, 1, 0);
        add_dep = enc(OP_R, 6, 5, 7);
        step(1, 1, 32'h200, lw5, mk_ctrl(1, 0), 0, 0);
        step(1, 1, 32'h204, add_dep, mk_ctrl(0, 1), 0, 0);
        chk("lu_stall", 32'(obs_stall), 32'd1);
        chk("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("lu_bubble_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
        chk("lu_bubble_nop", bus.ex_instr_o, 32'h13);
        step(1, 1, 32'h204, add_dep, mk_ctrl(0, 1), 0, 0);
        chk("lu_release_stall", 32'(obs_stall), 32'd0);
        chk("lu_captured", bus.ex_pc_o, 32'h204);

        // No false hazard: lw x0 / add x1,x0,x0
        step(1, 1, 32'h300, enc(OP_LD, 0, 1, 0), mk_ctrl(1, 0), 0, 0);
        step(1, 1, 32'h304, enc(OP_R, 1, 0, 0), mk_ctrl(0, 1), 0, 0);
        chk("nf_x0", 32'(obs_stall), 32'd0);
        // lw x5 / lui x5 (rs1 field forced to 5)
        step(1, 1, 32'h308, lw5, mk_ctrl(1, 0), 0, 0);
        step(1, 1, 32'h30C, enc(OP_LUI, 5, 5, 0), mk_ctrl(0, 0), 0, 0);
        chk("nf_lui", 32'(obs_stall), 32'd0);
        // lw x5 / addi x1,x2,5
        step(1, 1, 32'h310, lw5, mk_ctrl(1, 0), 0, 0);
        step(1, 1, 32'h314, enc(OP_IMM, 1, 2, 5), mk_ctrl(0, 0), 0, 0);
        chk("nf_addi", 32'(obs_stall), 32'd0);

        // Flush beats hazard
        step(1, 1, 32'h400, lw5, mk_ctrl(1, 0), 0, 0);
        bcnt_before = m_bcnt;
        step(1, 1, 32'h404, add_dep, mk_ctrl(0, 1), 0, 1);
        chk("fl_stall", 32'(obs_stall), 32'd0);
        chk("fl_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("fl_bcnt_model", m_bcnt, bcnt_before);

        // Stall hold with flush and changing inputs
        step(1, 1, 32'h500, enc(OP_R, 3, 1, 2), mk_ctrl(0, 1), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, $urandom, $urandom, 16'($urandom), 1, 1);
            chk("hold_stall", 32'(obs_stall), 32'd1);
            chk("hold_pc", bus.ex_pc_o, 32'h500);
        end

        // Reset mid-stream while stalled
        step(0, 1, 32'h600, enc(OP_R, 3, 1, 2), 16'hFFFF, 1, 0);
        chk("rst_mid_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("rst_mid_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
        chk("rst_mid_instr", bus.ex_instr_o, 32'd0);

        // Invalid capture squashes control
        step(1, 0, 32'h700, enc(OP_R, 3, 1, 2), 16'hFFFF, 0, 0);
        chk("inv_ctrl", 32'(bus.ex_ctrl_o), 32'd0);

        // Random traffic with a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic st, fl;
            st = ($urandom_range(0, 4) == 0);
            fl = !st && ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), $urandom,
                 enc(opcs[$urandom_range(0, 5)], $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3)),
                 16'($urandom), st, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_pipeline.md
Name: id_ex_stage_pipeline

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures the decoded control bundle, operands, PC and instruction from the decode stage, and presents them to EX one cycle later. It inserts bubbles on load-use hazards and branch/jump flushes, and holds its contents under downstream stall.

Parameters:
DATA_W, 32, width of PC, instruction, register-file data and immediate
CNT_W, 32, width of each performance counter (used only with the optional feature)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous, active-low reset
id_valid_i  input  1  decode stage holds a valid instruction
pc_i  input  DATA_W  PC of the decode instruction
instr_i  input  DATA_W  raw decode instruction
rs1_data_i  input  DATA_W  register-file read port 1
rs2_data_i  input  DATA_W  register-file read port 2
imm_i  input  DATA_W  sign-extended immediate
ctrl_i  input  16  decoded control, packed MSB→LSB: rd_wren, op_a_sel, op_b_sel, mem_wren, is_load, br_unsigned, is_rs2, alu_op[3:0], mem_op[2:0], wb_sel[1:0]
ex_stall_i  input  1  EX/MEM cannot accept; hold register
ex_flush_i  input  1  taken branch/jump resolved in EX; kill decode instruction
id_stall_o  input-facing output  1  hold PC and IF/ID this cycle (combinational)
ex_valid_o  output  1  EX-stage instruction valid
ex_pc_o  output  DATA_W  registered PC
ex_instr_o  output  DATA_W  registered instruction
ex_rs1_data_o  output  DATA_W  registered rs1 data
ex_rs2_data_o  output  DATA_W  registered rs2 data
ex_imm_o  output  DATA_W  registered immediate
ex_ctrl_o  output  16  registered control bundle, same packing as ctrl_i

Behaviour:
- Reset (rst_ni=0 at posedge): ex_valid_o=0, every other registered output = 0. Reset wins over all other inputs, including mid-stall or mid-flush.
- Field extraction: rd = instr[11:7], rs1 = instr_i[19:15], rs2 = instr_i[24:20], opcode = instr_i[6:2].
- uses_rs1 = 1 unless opcode ∈ {01101 LUI, 00101 AUIPC, 11011 JAL}.
- uses_rs2 = ctrl_i is_rs2 bit.
- Load-use hazard (combinational), all of the following true:
  - id_valid_i and ex_valid_o
  - ex_ctrl_o is_load = 1
  - ex rd ≠ 0
  - (uses_rs1 and rs1 = ex rd) or (uses_rs2 and rs2 = ex rd)
- id_stall_o = ex_stall_i | (hazard & ~ex_flush_i).
- Per-cycle update priority (highest first):
  1. ex_stall_i=1: all registers hold; ex_flush_i is ignored (EX guarantees flush is asserted only with ex_stall_i=0).
  2. ex_flush_i=1: load bubble.
  3. Hazard: load bubble.
  4. Otherwise: capture all inputs; ex_valid_o = id_valid_i.
- Bubble definition:
  - ex_valid_o=0; ex_ctrl_o=0, so rd_wren=0 and mem_wren=0.
  - ex_instr_o = 0x00000013 (NOP).
  - PC and data registers may take any value; EX must not act on them when ex_valid_o=0.
- When id_valid_i=0 and capturing: ctrl register is forced to 0. Decode X-values on invalid or illegal opcodes never reach EX.
- Latency: one cycle ID→EX. A load-use hazard costs exactly one bubble. After the bubble, ex_is_load=0, so the hazard clears and the held instruction captures on the next edge.
- Back-to-back: with ex_stall_i held N cycles, the output stays constant for N cycles and id_stall_o=1 throughout.

Optional Feature:
Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt_o[CNT_W-1:0] and flush_cnt_o[CNT_W-1:0].
  - bubble_cnt_o increments on each cycle that loads a hazard bubble.
  - flush_cnt_o increments on each cycle that loads a flush bubble.
  - Both saturate at all-ones, clear on reset, and hold under ex_stall_i.
- Undefined: ports and counters are absent. Remaining behaviour is identical.

Test Plan:
- Reset mid-stream: ex_valid_o=1 with ex_stall_i=1, rst_ni=0 for one edge → next cycle ex_valid_o=0, ex_ctrl_o=0, ex_instr_o=0.
- Load-use: EX holds lw x5 (is_load=1, rd=5), ID holds add x6,x5,x7 → id_stall_o=1. Next cycle: ex_valid_o=0, ex_ctrl_o=0. Following cycle: add captured, id_stall_o=0.
- No false hazard:
  - EX lw x0 with ID add x1,x0,x0 → id_stall_o=0.
  - EX lw x5 with ID lui x5 → id_stall_o=0.
  - EX lw x5 with ID addi x1,x2,5 (rs2 field=5, is_rs2=0) → id_stall_o=0.
- Flush vs hazard: hazard and ex_flush_i=1 in the same cycle → id_stall_o=0, bubble loaded. With the feature: flush_cnt_o +1, bubble_cnt_o unchanged.
- Stall hold: ex_stall_i=1 for 3 cycles with ex_flush_i=1 and changing inputs → outputs constant, id_stall_o=1 all 3 cycles.
- Invalid capture: id_valid_i=0, ctrl_i=16'hFFFF → ex_valid_o=0, ex_ctrl_o=16'h0000.
